// File: rtl/layer_generator.sv
// Per-row platform generator: 8 LFSR-driven GEN cycles compose a row, which COMMIT publishes and READY holds until a jump consumes it.
// Jump at edge T gives a fresh row after edge T+9; jumps during GEN/COMMIT set sticky overrun. LAYER_GEN_SAFE_START_EN adds hazard-free start rows.
module layer_generator #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          DENSITY    = 3,
  parameter int          HAZARD     = 2,
  parameter int          PATH_START = 3
`ifdef LAYER_GEN_SAFE_START_EN
  , parameter int        SAFE_ROWS  = 5
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       jump_left,
  input  logic       jump_right,
  output logic [0:6] layer_map_out,
  output logic [0:6] block_type_out,
  output logic       row_ready,
  output logic [2:0] path_col,
  output logic       overrun
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [3:0]  DENS     = 4'(DENSITY);
  localparam logic [3:0]  HAZ      = 4'(HAZARD);
  localparam logic [2:0]  PSTART   = 3'(PATH_START);

  typedef enum logic [1:0] {IDLE, GEN, COMMIT, READY} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  path_q, path_d;
  logic [2:0]  spath_q, spath_d;
  logic [0:6]  map_q, map_d, blk_q, blk_d;
  logic [0:6]  smap_q, smap_d, sblk_q, sblk_d;
  logic        ready_q, ready_d;
  logic        overrun_q, overrun_d;
  logic        first_q, first_d;
`ifdef LAYER_GEN_SAFE_START_EN
  logic [2:0]  safe_q, safe_d;
`endif

  logic       jump;
  logic       fb;
  logic       present;
  logic       hazard;
  logic [2:0] col;

  always_comb begin
    jump    = jump_left | jump_right;
    fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    col     = k_q - 3'd1;
    present = ({1'b0, lfsr_q[2:0]} < DENS);
    hazard  = present && ({1'b0, lfsr_q[5:3]} < HAZ);

    state_d   = state_q;
    lfsr_d    = lfsr_q;
    k_d       = k_q;
    path_d    = path_q;
    spath_d   = spath_q;
    map_d     = map_q;
    blk_d     = blk_q;
    smap_d    = smap_q;
    sblk_d    = sblk_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    first_d   = first_q;
`ifdef LAYER_GEN_SAFE_START_EN
    safe_d    = safe_q;
`endif

    if (!module_en) begin
      // LFSR deliberately keeps running state across disable; only the row/path state is cleared
      state_d   = IDLE;
      k_d       = '0;
      path_d    = PSTART;
      map_d     = '0;
      blk_d     = '0;
      ready_d   = 1'b0;
      overrun_d = 1'b0;
      first_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GEN;
          k_d     = '0;
          first_d = 1'b1;
`ifdef LAYER_GEN_SAFE_START_EN
          safe_d  = 3'(SAFE_ROWS);
`endif
        end
        GEN: begin
          lfsr_d = {lfsr_q[14:0], fb};
          k_d    = k_q + 3'd1;
          if (jump) overrun_d = 1'b1;
          if (k_q == 3'd0) begin
            smap_d = '0;
            sblk_d = '0;
            if (first_q)              spath_d = path_q;
            else if (path_q == 3'd0)  spath_d = 3'd1;
            else if (path_q == 3'd6)  spath_d = 3'd5;
            else if (lfsr_q[0])       spath_d = path_q + 3'd1;
            else                      spath_d = path_q - 3'd1;
          end else begin
            for (int i = 0; i < 7; i++) begin
              if (col == 3'(i)) begin
                smap_d[i] = (col == spath_q) ? 1'b1 : present;
                sblk_d[i] = (col == spath_q) ? 1'b0 : hazard;
              end
            end
          end
          if (k_q == 3'd7) state_d = COMMIT;
        end
        COMMIT: begin
          map_d   = smap_q;
          blk_d   = sblk_q;
`ifdef LAYER_GEN_SAFE_START_EN
          if (safe_q != 3'd0) begin
            blk_d  = '0;
            safe_d = safe_q - 3'd1;
          end
`endif
          path_d  = spath_q;
          ready_d = 1'b1;
          first_d = 1'b0;
          if (jump) overrun_d = 1'b1;
          state_d = READY;
        end
        READY: begin
          if (jump) begin
            ready_d = 1'b0;
            k_d     = '0;
            state_d = GEN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      k_q       <= '0;
      path_q    <= PSTART;
      spath_q   <= PSTART;
      map_q     <= '0;
      blk_q     <= '0;
      smap_q    <= '0;
      sblk_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      first_q   <= 1'b1;
`ifdef LAYER_GEN_SAFE_START_EN
      safe_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      k_q       <= k_d;
      path_q    <= path_d;
      spath_q   <= spath_d;
      map_q     <= map_d;
      blk_q     <= blk_d;
      smap_q    <= smap_d;
      sblk_q    <= sblk_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      first_q   <= first_d;
`ifdef LAYER_GEN_SAFE_START_EN
      safe_q    <= safe_d;
`endif
    end
  end

  assign layer_map_out  = map_q;
  assign block_type_out = blk_q;
  assign row_ready      = ready_q;
  assign path_col       = path_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_layer_generator.sv
// Scoreboard bench for layer_generator: three instances (default, DENSITY=0/HAZARD=8, DENSITY=8/HAZARD=8) share stimulus.
// Expected rows are modelled when a trigger is driven and compared when row_ready rises.
module tb_layer_generator;

  logic clk = 1'b0;
  logic rst, module_en, jump_left, jump_right;

  logic [0:6] map_a, blk_a, map_b, blk_b, map_c, blk_c;
  logic       rr_a, rr_b, rr_c, ovr_a, ovr_b, ovr_c;
  logic [2:0] path_a, path_b, path_c;

  layer_generator dut_a (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map_a), .block_type_out(blk_a), .row_ready(rr_a), .path_col(path_a), .overrun(ovr_a));

  layer_generator #(.DENSITY(0), .HAZARD(8)) dut_b (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map_b), .block_type_out(blk_b), .row_ready(rr_b), .path_col(path_b), .overrun(ovr_b));

  layer_generator #(.DENSITY(8), .HAZARD(8)) dut_c (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map_c), .block_type_out(blk_c), .row_ready(rr_c), .path_col(path_c), .overrun(ovr_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    bit         first;
    logic [2:0] path;
    logic [0:6] map_a, blk_a, map_b, blk_b, map_c, blk_c;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_lfsr  = 16'hACE1;
  int          m_path  = 3;
  bit          m_first = 1'b1;
  int          m_safe  = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_row(input logic [15:0] l_in, input int np, input int dens, input int haz,
                           output logic [0:6] map, output logic [0:6] blk);
    logic [15:0] l;
    l   = l_in;
    map = '0;
    blk = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == np) begin
        map[c] = 1'b1;
      end else begin
        map[c] = (int'(l[2:0]) < dens);
        blk[c] = map[c] && (int'(l[5:3]) < haz);
      end
      l = lfsr_step(l);
    end
  endtask

  // Called at the moment a row-starting input is driven; the row must appear 10 counter ticks later.
  task automatic push_row();
    exp_t        e;
    int          np;
    logic [15:0] l1;
    logic [0:6]  m, b;
    if (m_first)          np = m_path;
    else if (m_path == 0) np = 1;
    else if (m_path == 6) np = 5;
    else                  np = m_lfsr[0] ? m_path + 1 : m_path - 1;
    l1 = lfsr_step(m_lfsr);
    model_row(l1, np, 3, 2, m, b); e.map_a = m; e.blk_a = b;
    model_row(l1, np, 0, 8, m, b); e.map_b = m; e.blk_b = b;
    model_row(l1, np, 8, 8, m, b); e.map_c = m; e.blk_c = b;
`ifdef LAYER_GEN_SAFE_START_EN
    if (m_safe > 0) begin
      e.blk_a = '0;
      e.blk_b = '0;
      e.blk_c = '0;
      m_safe--;
    end
`endif
    e.path  = 3'(np);
    e.first = m_first;
    e.cyc   = cyc + 10;
    for (int i = 0; i < 8; i++) m_lfsr = lfsr_step(m_lfsr);
    m_path  = np;
    m_first = 1'b0;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enable();
    module_en = 1'b1;
    m_first   = 1'b1;
    m_path    = 3;
    m_safe    = 5;
    push_row();
    tick();
  endtask

  task automatic jump(input logic l, input logic r, input bit expect_row);
    jump_left  = l;
    jump_right = r;
    if (expect_row) push_row();
    tick();
    jump_left  = 1'b0;
    jump_right = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_map"}, 32'(map_a), 32'd0);
    check({tag, "_blk"}, 32'(blk_a), 32'd0);
    check({tag, "_rr"}, 32'(rr_a), 32'd0);
    check({tag, "_ovr"}, 32'(ovr_a), 32'd0);
    check({tag, "_path"}, 32'(path_a), 32'd3);
  endtask

  // Row monitor: compares every fresh row of all three instances against the scoreboard.
  logic prev_rr    = 1'b0;
  int   rows_seen  = 0;
  int   hit0       = 0;
  int   hit6       = 0;
  int   last_path  = 3;

  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (rr_a && !prev_rr) begin
        rows_seen++;
        check("row_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("latency", 32'(cyc), 32'(e.cyc));
          check("rr_sync", {30'd0, rr_b, rr_c}, 32'd3);
          check("path", 32'(path_a), 32'(e.path));
          check("path_range", 32'(path_a <= 3'd6), 32'd1);
          check("map_a", 32'(map_a), 32'(e.map_a));
          check("blk_a", 32'(blk_a), 32'(e.blk_a));
          check("map_d0", 32'(map_b), 32'(e.map_b));
          check("blk_d0", 32'(blk_b), 32'(e.blk_b));
          check("map_d8", 32'(map_c), 32'(e.map_c));
          check("blk_d8", 32'(blk_c), 32'(e.blk_c));
          check("blk_outside_map", 32'(blk_a & ~map_a), 32'd0);
          check("path_safe", {30'd0, map_a[path_a], blk_a[path_a]}, 32'd2);
          if (!e.first) begin
            d = int'(path_a) - last_path;
            check("path_step", 32'(d == 1 || d == -1), 32'd1);
            if (last_path == 6) begin check("edge6_next", 32'(path_a), 32'd5); hit6++; end
            if (last_path == 0) begin check("edge0_next", 32'(path_a), 32'd1); hit0++; end
          end
          last_path = int'(path_a);
        end
      end
      prev_rr = rr_a;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int rs;
    rst        = 1'b1;
    module_en  = 1'b0;
    jump_left  = 1'b0;
    jump_right = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset");

    // First row after enable keeps the start column
    enable();
    repeat (11) tick();
    check("first_row_pending", 32'(q.size()), 32'd0);
    check("first_rr", 32'(rr_a), 32'd1);
    check("first_path", 32'(path_a), 32'd3);
    check("first_map3", 32'(map_a[3]), 32'd1);
    check("first_blk3", 32'(blk_a[3]), 32'd0);

    // Long random walk with spaced jumps (left, right or both)
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 2))
        0:       jump(1'b1, 1'b0, 1'b1);
        1:       jump(1'b0, 1'b1, 1'b1);
        default: jump(1'b1, 1'b1, 1'b1);
      endcase
      repeat (11) tick();
      check("row_pending", 32'(q.size()), 32'd0);
      check("no_overrun", 32'(ovr_a), 32'd0);
    end
    check("hit_col6", 32'(hit6 > 0), 32'd1);
    check("hit_col0", 32'(hit0 > 0), 32'd1);

    // Both jump inputs in one cycle give exactly one row
    rs = rows_seen;
    jump(1'b1, 1'b1, 1'b1);
    repeat (20) tick();
    check("both_one_row", 32'(rows_seen - rs), 32'd1);
    check("both_rr", 32'(rr_a), 32'd1);

    // Second jump during generation: sticky overrun, row still on time
    jump(1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    jump(1'b0, 1'b1, 1'b0);
    check("overrun_set", 32'(ovr_a), 32'd1);
    repeat (12) tick();
    check("overrun_sticky", 32'(ovr_a), 32'd1);
    check("overrun_row_done", 32'(q.size()), 32'd0);
    check("overrun_rr", 32'(rr_a), 32'd1);
    module_en = 1'b0;
    tick();
    check_idle_outputs("disable");

    // Reset in the middle of generation discards the row
    enable();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_gen_rst");
    q.delete();
    m_lfsr    = 16'hACE1;
    module_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("post_rst_idle");

    enable();
    repeat (11) tick();
    for (int i = 0; i < 8; i++) begin
      jump(1'b0, 1'b1, 1'b1);
      repeat (11) tick();
      check("restart_row_pending", 32'(q.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer_generator.md
Name: layer_generator

Overview:
- Producer of the per-row platform stream consumed by the layer shifter/blocks stage.
- Presents the next incoming row as two 7-bit vectors: `layer_map_out` (platform present) and `block_type_out` (1 = hazard block).
- Holds each row stable until a jump consumes it, then composes the next row from an LFSR.
- Guarantees a reachable, hazard-free path column in every row.

Parameters:
- SEED, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'hACE1.
- DENSITY, 3, presence threshold 0..8; a non-path column is present when its 3-bit draw < DENSITY.
- HAZARD, 2, hazard threshold 0..8; a present non-path column is a hazard when its 3-bit draw < HAZARD.
- PATH_START, 3, initial path column 0..6.
- SAFE_ROWS, 5, count of hazard-free rows after enable (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- module_en  in  1  game running; low forces IDLE.
- jump_left  in  1  one-cycle jump pulse.
- jump_right  in  1  one-cycle jump pulse.
- layer_map_out  out  [0:6]  current row, platform present per column.
- block_type_out  out  [0:6]  current row, 1 = hazard, 0 = normal; bit is 0 wherever `layer_map_out` is 0.
- row_ready  out  1  current row is a fresh, unconsumed row.
- path_col  out  3  column of the guaranteed safe block in the current row.
- overrun  out  1  sticky; a jump arrived while a row was being generated.

Behaviour:
- Synchronous reset; all state updates on the posedge of `clk`.
- Reset values:
  - `layer_map_out` = 0, `block_type_out` = 0, `row_ready` = 0, `overrun` = 0.
  - `path_col` = PATH_START, LFSR = SEED, state IDLE.
- `jump` = `jump_left | jump_right`. Both asserted in one cycle counts as one jump.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts left with feedback into bit 0.
  - Advances exactly once per cycle in GEN, and holds in all other states.
- States:
  - IDLE: outputs as reset, `path_col` = PATH_START. Go to GEN when `module_en` = 1.
  - GEN: 8 cycles, tracked by step counter k = 0..7.
    - k = 0: direction from lfsr[0] (1 = +1, 0 = −1). At column 0 force +1; at column 6 force −1. Next path column = `path_col` ± 1. The first row after IDLE uses PATH_START unchanged.
    - k = 1..7: compose column c = k−1 into a shadow row.
      - Path column: present, normal.
      - Other columns: present if lfsr[2:0] < DENSITY; hazard if present and lfsr[5:3] < HAZARD.
  - COMMIT: 1 cycle.
    - Copy the shadow row to the outputs and update `path_col`.
    - `row_ready` ← 1.
    - Go to READY.
  - READY: outputs held. On `jump`: `row_ready` ← 0, go to GEN.
- Latency:
  - Jump sampled at edge T → `row_ready` high and new row visible after edge T+9.
  - During those 9 cycles, outputs keep the consumed row.
- Jump during GEN or COMMIT:
  - `overrun` ← 1 (sticky until reset or `module_en` low).
  - Generation continues.
  - Jumps are not queued.
- `module_en` falling in any state: next cycle IDLE with reset outputs, `overrun` cleared. LFSR keeps its value (not reseeded).
- `rst` mid-GEN: shadow row discarded, full reset values.
- Thresholds: DENSITY = 0 gives only the path block. HAZARD = 0 gives no hazards. DENSITY = 8 fills every column.

Optional Feature:
- Macro: LAYER_GEN_SAFE_START_EN.
- Defined:
  - A 3-bit counter loads SAFE_ROWS on leaving IDLE and decrements at each COMMIT while nonzero.
  - While it is nonzero at COMMIT, the committed `block_type_out` is forced to 0.
  - Presence is unchanged.
- Undefined:
  - No counter.
  - Hazards are allowed from the first row.
  - SAFE_ROWS is ignored.

Test Plan:
- Reset, `module_en` = 1, SEED default → `row_ready` rises 9 cycles after enable, `path_col` = 3, `layer_map_out[3]` = 1, `block_type_out[3]` = 0.
- 1000 jump pulses spaced 12 cycles → every row: `path_col` differs from previous by exactly 1 and stays in 0..6; path bit present/normal; `block_type_out` & ~`layer_map_out` = 0; `overrun` stays 0.
- Force `path_col` to 6 (drive jumps until reached) → the next row always has `path_col` = 5. Mirror case at 0 → next row has 1.
- Jump then a second jump 4 cycles later → `overrun` = 1 and remains 1. Row still commits at T+9. Dropping `module_en` clears `overrun` and zeroes outputs next cycle.
- Simultaneous `jump_left` & `jump_right` pulse → exactly one new row, LFSR advanced exactly 8 steps (compare to model).
- DENSITY = 0, HAZARD = 8 → only the path bit is set in every row. With LAYER_GEN_SAFE_START_EN, DENSITY = 8, HAZARD = 8 → first 5 rows have `block_type_out` = 0; the 6th row has all non-path columns = 1.
